core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle sequencer for the tiny RV32 core. Owns the PC and the instruction register.
//  Serially loads each 32-bit instruction as 4 bytes over the byte port.
//  Steps the combinational decoder and ALU through DECODE/EXEC/WB, one instruction at a time.
//  Issues the register-file write strobe and the PC update.
// PARAMETERS
//  PC_W      8      PC width in bits; PC arithmetic wraps modulo 2^PC_W
//  RESET_PC  0      PC value loaded on reset (PC_W bits)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      IDLE/HALT -> FETCH (level or pulse, sampled per cycle)
//  byte_in      in   8      instruction byte, little-endian order (byte0 = instr[7:0])
//  byte_valid   in   1      byte_in valid this cycle
//  byte_ready   out  1      sequencer accepts a byte this cycle (FETCH only)
//  instr        out  32     instruction register, feeds decoder
//  instr_valid  out  1      instr stable and decodable (DECODE, EXEC, WB)
//  dec_reg_we   in   1      decoder reg_we
//  dec_branch   in   1      decoder branch
//  alu_zero     in   1      ALU result == 0 (valid in EXEC/WB)
//  alu_en       out  1      ALU operand/result registers capture (EXEC only)
//  rf_we        out  1      one-cycle register-file write strobe
//  pc           out  PC_W   current PC
//  halted       out  1      in HALT state
//  busy         out  1      state != IDLE and != HALT
//  instr_count  out  8      retired instructions, wraps 0xFF->0x00
// BEHAVIOUR
//  Reset (async, immediate, any state):
//   state=IDLE, pc=RESET_PC, instr=0, byte index=0, instr_count=0, all strobes 0.
//  States: IDLE(0) FETCH(1) DECODE(2) EXEC(3) WB(4) HALT(5).
//   IDLE   : start=1 -> FETCH.
//   FETCH  : byte_ready=1. Byte accepted on byte_valid&byte_ready.
//            Byte k (k=0..3) goes to instr[8k+7:8k]; index increments.
//            Cycle after the 4th accept -> DECODE, index=0.
//            No accept while byte_valid=0; no timeout.
//   DECODE : 1 cycle, instr_valid=1.
//            instr==32'h0 -> HALT (not retired, pc unchanged); else -> EXEC.
//   EXEC   : 1 cycle, alu_en=1 -> WB.
//   WB     : 1 cycle.
//            rf_we = dec_reg_we & (instr[11:7]!=0); writes to x0 are never strobed.
//            Next pc = pc + immB when dec_branch & alu_zero, else pc + 4.
//            immB = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}), truncated to PC_W.
//            instr_count++. -> FETCH.
//   HALT   : halted=1, byte_ready=0. start=1 -> FETCH; pc and instr_count retained.
//  Latency: 4 accepted bytes + 3 cycles per instruction; minimum 7 cycles/instr.
//  byte_valid outside FETCH is ignored (no accept, no state effect).
//  start outside IDLE/HALT is ignored.
//  rf_we and alu_en are never high outside WB and EXEC respectively.
//  Branch with alu_zero=0 is a plain pc+4.
//  Non-branch instructions never use immB.
//  Outputs are registered state decodes; no combinational path from byte_in to outputs.
// TESTING
//  T1 reset: assert rst mid-FETCH after 2 bytes.
//     -> state IDLE, pc=0, instr=0, count=0.
//     -> After start, 4 fresh bytes are needed before DECODE.
//  T2 ADDI x1,x0,5: bytes 93,00,50,00.
//     -> instr=0x00500093.
//     -> rf_we=1 for exactly 1 cycle, 3 cycles after the last byte.
//     -> pc 0->4, count=1.
//  T3 BEQ taken: pc=8, instr 0xFE000CE3 (offset -8), alu_zero=1 -> pc=0.
//     Same with alu_zero=0 -> pc=12; rf_we stays 0 in both cases.
//  T4 ADD x0,x1,x2 (0x00208033) with dec_reg_we=1.
//     -> rf_we never asserted, pc+=4, count increments.
//  T5 halt: bytes 00,00,00,00.
//     -> HALT, halted=1, byte_ready=0, pc and count unchanged.
//     -> start -> FETCH with same pc.
//  T6 wrap: PC_W=8, pc=0xFC, ADDI -> pc=0x00.
//     Count at 0xFF -> 0x00 after the next retire.
//     byte_valid held during DECODE/EXEC/WB -> no bytes consumed.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer for the tiny RV32 core: byte-serial fetch, then
// DECODE/EXEC/WB stepping, register-file write strobe and PC update.
module core_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      byte_in,
    input  logic            byte_valid,
    output logic            byte_ready,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            dec_reg_we,
    input  logic            dec_branch,
    input  logic            alu_zero,
    output logic            alu_en,
    output logic            rf_we,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            busy,
    output logic [7:0]      instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [31:0]     imm_b;
    logic            take_br;

    // B-type immediate, sign-extended to 32 bits before truncation to PC_W
    assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                    instr_q[30:25], instr_q[11:8], 1'b0};
    assign take_br = dec_branch & alu_zero;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (byte_valid) begin
                    instr_d[{idx_q, 3'b000} +: 8] = byte_in;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (instr_q == 32'h0) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                pc_d    = pc_q + (take_br ? PC_W'(imm_b) : PC_W'(4));
                cnt_d   = cnt_q + 8'd1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // x0 is hardwired to zero, so its writes are suppressed here
    assign rf_we       = (state_q == S_WB) & dec_reg_we & (|instr_q[11:7]);
    assign byte_ready  = (state_q == S_FETCH);
    assign instr_valid = (state_q == S_DECODE) | (state_q == S_EXEC)
                       | (state_q == S_WB);
    assign alu_en      = (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);
    assign busy        = (state_q != S_IDLE) & (state_q != S_HALT);
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: timeline scoreboard checked every
// cycle plus directed literal expectations.
module tb_core_sequencer;

    localparam int PC_W = 8;
    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] BEQ8 = 32'hFE000CE3;
    localparam logic [31:0] BEQ20 = 32'hFE0006E3;
    localparam logic [31:0] ADDX0 = 32'h00208033;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [7:0]      byte_in = 8'h00;
    logic            byte_valid = 1'b0;
    logic            byte_ready;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            dec_reg_we = 1'b0;
    logic            dec_branch = 1'b0;
    logic            alu_zero = 1'b0;
    logic            alu_en;
    logic            rf_we;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic            busy;
    logic [7:0]      instr_count;

    core_sequencer #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .instr(instr), .instr_valid(instr_valid),
        .dec_reg_we(dec_reg_we), .dec_branch(dec_branch), .alu_zero(alu_zero),
        .alu_en(alu_en), .rf_we(rf_we), .pc(pc), .halted(halted),
        .busy(busy), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // model state
    logic [7:0]  m_pc = 8'h00;
    logic [7:0]  m_cnt = 8'h00;
    logic [31:0] m_instr = 32'h0;
    bit          m_idle = 1'b1;
    bit          m_halt = 1'b0;
    bit          m_rfw = 1'b0;
    bit          chk_en = 1'b0;
    int          t_dec = -100;
    int          t_end = -100;
    int          t_exec = -100;
    int          t_wb = -100;
    int          rf_pulses = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] br_off(input logic [31:0] w);
        int off;
        off = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0)
            + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        return 8'(off);
    endfunction

    always @(negedge clk) begin
        bit win;
        if (rf_we) rf_pulses <= rf_pulses + 1;
        if (chk_en && !rst) begin
            win = (cyc >= t_dec) && (cyc <= t_end);
            chk("pc", 32'(pc), 32'(m_pc));
            chk("count", 32'(instr_count), 32'(m_cnt));
            chk("instr_valid", 32'(instr_valid), 32'(win));
            chk("alu_en", 32'(alu_en), 32'(cyc == t_exec));
            chk("rf_we", 32'(rf_we), 32'((cyc == t_wb) && m_rfw));
            chk("byte_ready", 32'(byte_ready),
                32'(!m_idle && !m_halt && !win));
            chk("busy", 32'(busy), 32'(!m_idle && !m_halt));
            chk("halted", 32'(halted), 32'(m_halt));
            if (win) chk("instr", instr, m_instr);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_idle = 1'b0;
        m_halt = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input bit we, input bit br,
                        input bit z, input bit gaps, input bit hold);
        m_instr = w;
        dec_reg_we = we;
        dec_branch = br;
        alu_zero = z;
        for (int k = 0; k < 4; k++) begin
            if (gaps) begin
                byte_valid = 1'b0;
                byte_in = 8'h5A;
                tick();
            end
            byte_in = w[8*k +: 8];
            byte_valid = 1'b1;
            if (k == 3) begin
                t_dec = cyc + 1;
                t_end = (w == 32'h0) ? t_dec : t_dec + 2;
                t_exec = (w == 32'h0) ? -100 : t_dec + 1;
                t_wb = (w == 32'h0) ? -100 : t_dec + 2;
                m_rfw = we && (w[11:7] != 5'd0);
            end
            tick();
        end
        if (hold) byte_in = 8'hAA;
        else byte_valid = 1'b0;
        if (w == 32'h0) begin
            byte_valid = 1'b0;
            tick();
            m_halt = 1'b1;
        end else begin
            tick();
            tick();
            tick();
            byte_valid = 1'b0;
            m_pc = m_pc + ((br && z) ? br_off(w) : 8'd4);
            m_cnt = m_cnt + 8'd1;
        end
    endtask

    initial begin
        #1;
        chk("por_pc", 32'(pc), 32'h0);
        chk("por_instr", instr, 32'h0);
        chk("por_count", 32'(instr_count), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'h0);

        // ADDI x1,x0,5
        do_start();
        rf_pulses = 0;
        send(ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_instr", instr, 32'h00500093);
        chk("t2_pc", 32'(pc), 32'h4);
        chk("t2_count", 32'(instr_count), 32'h1);
        chk("t2_rf_pulses", 32'(rf_pulses), 32'h1);

        // reset in the middle of a fetch
        byte_in = 8'h93;
        byte_valid = 1'b1;
        tick();
        byte_in = 8'h00;
        tick();
        byte_valid = 1'b0;
        rst = 1'b1;
        m_pc = 8'h00;
        m_cnt = 8'h00;
        m_idle = 1'b1;
        m_halt = 1'b0;
        #1;
        chk("t1_instr", instr, 32'h0);
        chk("t1_pc", 32'(pc), 32'h0);
        chk("t1_count", 32'(instr_count), 32'h0);
        chk("t1_busy", 32'(busy), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        do_start();
        send(ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(ADDI, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_pc8", 32'(pc), 32'h8);

        // BEQ taken and not taken
        rf_pulses = 0;
        send(BEQ8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_taken_pc", 32'(pc), 32'h0);
        send(ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rf_pulses = 0;
        send(BEQ8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_fall_pc", 32'(pc), 32'hC);
        chk("t3_rf_pulses", 32'(rf_pulses), 32'h0);

        // ADD x0,x1,x2 never strobes the register file
        send(ADDX0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_pc", 32'(pc), 32'h10);
        chk("t4_count", 32'(instr_count), 32'h7);
        chk("t4_rf_pulses", 32'(rf_pulses), 32'h0);

        // halt word, then restart at the same pc
        send(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_halted", 32'(halted), 32'h1);
        chk("t5_ready", 32'(byte_ready), 32'h0);
        byte_in = 8'h13;
        byte_valid = 1'b1;
        tick();
        tick();
        tick();
        byte_valid = 1'b0;
        chk("t5_pc", 32'(pc), 32'h10);
        chk("t5_count", 32'(instr_count), 32'h7);
        do_start();
        chk("t5_restart_ready", 32'(byte_ready), 32'h1);
        chk("t5_restart_pc", 32'(pc), 32'h10);

        // pc wrap via branch to 0xFC, then ADDI wraps to 0x00
        send(BEQ20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_pc_fc", 32'(pc), 32'hFC);
        send(ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_pc_wrap", 32'(pc), 32'h00);
        for (int k = 0; k < 400 && m_cnt != 8'hFF; k++)
            send(ADDI, 1'b1, 1'b0, 1'b0, 1'b0, k[0]);
        chk("t6_count_ff", 32'(instr_count), 32'hFF);
        send(ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_count_wrap", 32'(instr_count), 32'h00);

        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
